cache_miss_ctrl: RTL and testbench

- Miss handler directly downstream of the 4-way, 4-set cache.
- Accepts a miss plus the 4 lines of the indexed set, and picks the victim way.
- Writes back the victim to main memory if it is valid and dirty, then fetches the missing word from memory (read miss only).
- Returns a fill line that the cache writes into the victim way.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_miss_ctrl_if.sv | 36 +++
 rtl/victim_select.sv | 45 ++++
 rtl/cache_miss_ctrl.sv | 129 ++++++++++++
 tb/tb_cache_miss_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache line layout, widths and miss-handler states
package cache_pkg;

    localparam int VALID    = 8;
    localparam int LRU      = 7;
    localparam int DIRTY    = 6;
    localparam int TAG_MSB  = 5;
    localparam int TAG_LSB  = 3;
    localparam int DATA_MSB = 2;
    localparam int DATA_LSB = 0;

    localparam int ADDR_W = 5;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 3;
    localparam int IDX_W  = 2;
    localparam int WAYS   = 4;
    localparam int LINE_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_FETCH = 2'd2,
        ST_FILL  = 2'd3
    } miss_state_e;

    // Freshly filled lines are always valid and most-recently-used.
    function automatic logic [LINE_W-1:0] make_fill_line(
        input logic              dirty,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, 1'b1, dirty, tag, data};
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// rtl/cache_miss_ctrl_if.sv - miss, fill and memory handshake bundle of the miss controller
interface cache_miss_ctrl_if;
    import cache_pkg::*;

    logic                     miss_valid;
    logic                     miss_ready;
    logic [ADDR_W-1:0]        miss_addr;
    logic                     miss_write;
    logic [DATA_W-1:0]        miss_data;
    logic [WAYS*LINE_W-1:0]   set_lines;

    logic                     fill_valid;
    logic [IDX_W-1:0]         fill_way;
    logic [IDX_W-1:0]         fill_index;
    logic [LINE_W-1:0]        fill_line;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ack;
    logic [DATA_W-1:0]        mem_rdata;

    modport master (
        output miss_valid, miss_addr, miss_write, miss_data, set_lines, mem_ack, mem_rdata,
        input  miss_ready, fill_valid, fill_way, fill_index, fill_line,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  miss_valid, miss_addr, miss_write, miss_data, set_lines, mem_ack, mem_rdata,
        output miss_ready, fill_valid, fill_way, fill_index, fill_line,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/victim_select.sv
// rtl/victim_select.sv - picks the replacement way: first invalid, else first non-LRU, else way 0
module victim_select
    import cache_pkg::*;
(
    input  logic [WAYS*LINE_W-1:0] set_lines,
    output logic [IDX_W-1:0]       way,
    output logic [LINE_W-1:0]      vline
);

    logic found_inv;
    logic found_lru;
    logic [IDX_W-1:0] inv_way;
    logic [IDX_W-1:0] lru_way;

    always_comb begin
        found_inv = 1'b0;
        found_lru = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found_inv && !set_lines[i*LINE_W + VALID]) begin
                found_inv = 1'b1;
                inv_way   = IDX_W'(i);
            end
            if (!found_lru && !set_lines[i*LINE_W + LRU]) begin
                found_lru = 1'b1;
                lru_way   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (found_inv)      way = inv_way;
        else if (found_lru) way = lru_way;
        else                way = '0;
    end

    always_comb begin
        vline = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way == IDX_W'(i)) vline = set_lines[i*LINE_W +: LINE_W];
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - miss handler: victim choice, dirty write-back, fetch and fill
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    cache_miss_ctrl_if.slave  bus,
    output logic              err,
    output logic [7:0]        wb_count
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WB    = ST_WB;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_FILL  = ST_FILL;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  way_q;
    logic [TAG_W-1:0]  vtag_q;
    logic [DATA_W-1:0] vdata_q;
    logic [3:0]        tmo_q;
    logic              err_q;

    logic [IDX_W-1:0]  vs_way;
    logic [LINE_W-1:0] vs_line;
    logic              accept;
    logic              timeout_hit;

    victim_select u_victim_select (
        .set_lines (bus.set_lines),
        .way       (vs_way),
        .vline     (vs_line)
    );

    assign accept      = bus.miss_valid && (state == S_IDLE);
    assign timeout_hit = (tmo_q == 4'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            way_q    <= '0;
            vtag_q   <= '0;
            vdata_q  <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            wb_count <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.miss_addr;
                        write_q <= bus.miss_write;
                        data_q  <= bus.miss_data;
                        way_q   <= vs_way;
                        vtag_q  <= vs_line[TAG_MSB:TAG_LSB];
                        vdata_q <= vs_line[DATA_MSB:DATA_LSB];
                        tmo_q   <= '0;
                        if (vs_line[VALID] && vs_line[DIRTY]) state <= S_WB;
                        else if (bus.miss_write)              state <= S_FILL;
                        else                                  state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (bus.mem_ack) begin
                        if (wb_count != 8'hFF) wb_count <= wb_count + 8'd1;
                        tmo_q <= '0;
                        state <= write_q ? S_FILL : S_FETCH;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        rdata_q <= bus.mem_rdata;
                        state   <= S_FILL;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from state so an async reset drops the memory request immediately.
    always_comb begin
        bus.miss_ready = (state == S_IDLE);
        bus.mem_req    = (state == S_WB) || (state == S_FETCH);
        bus.mem_we     = (state == S_WB);
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        if (state == S_WB) begin
            bus.mem_addr  = {vtag_q, addr_q[IDX_W-1:0]};
            bus.mem_wdata = vdata_q;
        end else if (state == S_FETCH) begin
            bus.mem_addr  = addr_q;
        end
    end

    always_comb begin
        bus.fill_valid = (state == S_FILL);
        bus.fill_way   = way_q;
        bus.fill_index = addr_q[IDX_W-1:0];
        bus.fill_line  = '0;
        if (state == S_FILL)
            bus.fill_line = make_fill_line(write_q, addr_q[ADDR_W-1:IDX_W],
                                           write_q ? data_q : rdata_q);
    end

    assign err = err_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed self-checking bench for cache_miss_ctrl
module tb_cache_miss_ctrl;

    logic       clock;
    logic       reset_n;
    logic       err;
    logic [7:0] wb_count;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_fill = 0;
    int n_err  = 0;
    int n_req  = 0;

    cache_miss_ctrl_if bus();

    cache_miss_ctrl #(.TIMEOUT(15)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .err      (err),
        .wb_count (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset_n) begin
            if (bus.miss_valid && bus.miss_ready) n_acc <= n_acc + 1;
            if (bus.fill_valid) n_fill <= n_fill + 1;
            if (err) n_err <= n_err + 1;
            if (bus.mem_req) n_req <= n_req + 1;
        end
    end

    localparam logic [35:0] LINES_CLEAN = {9'b000100000, 9'b110000101, 9'b110000010, 9'b110001001};
    localparam logic [35:0] LINES_DIRTY = {9'b110000101, 9'b110000010, 9'b110001001, 9'b111010011};
    localparam logic [35:0] LINES_W1INV = {9'b110000101, 9'b110000010, 9'b000000000, 9'b110000001};
    localparam logic [35:0] LINES_W0INV = {9'b110000101, 9'b110000010, 9'b110001001, 9'b000000000};

    task automatic test_reset;
        reset_n = 1'b0;
        bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_write = 1'b0; bus.miss_data = '0;
        bus.set_lines = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clock);
        checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus.miss_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", bus.mem_req); end
        checks++; if (bus.fill_valid !== 1'b0) begin errors++; $display("FAIL rst_fill: got %b exp 0", bus.fill_valid); end
        checks++; if (bus.mem_addr !== 5'b0) begin errors++; $display("FAIL rst_addr: got %b exp 00000", bus.mem_addr); end
        checks++; if (err !== 1'b0 || wb_count !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got err=%b cnt=%0d exp 0/0", err, wb_count); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_clean_read;
        int acc0, fill0;
        acc0 = n_acc; fill0 = n_fill;
        bus.set_lines = LINES_CLEAN; bus.miss_addr = 5'b01100; bus.miss_write = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 3'b101; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.miss_valid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL cr_fetch_req: got req=%b we=%b exp 1/0", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== 5'b01100) begin errors++; $display("FAIL cr_fetch_addr: got %b exp 01100", bus.mem_addr); end
        checks++; if (bus.miss_ready !== 1'b0 || bus.fill_valid !== 1'b0) begin errors++; $display("FAIL cr_busy: got ready=%b fill=%b exp 0/0", bus.miss_ready, bus.fill_valid); end
        @(negedge clock);
        checks++; if (bus.fill_valid !== 1'b1) begin errors++; $display("FAIL cr_fill_valid: got %b exp 1", bus.fill_valid); end
        checks++; if (bus.fill_line !== 9'b110011101) begin errors++; $display("FAIL cr_fill_line: got %b exp 110011101", bus.fill_line); end
        checks++; if (bus.fill_way !== 2'd3 || bus.fill_index !== 2'd0) begin errors++; $display("FAIL cr_fill_way_idx: got %0d/%0d exp 3/0", bus.fill_way, bus.fill_index); end
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 5'b0) begin errors++; $display("FAIL cr_fill_noreq: got req=%b addr=%b exp 0/00000", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b0;
        @(negedge clock);
        checks++; if (bus.miss_ready !== 1'b1 || bus.fill_valid !== 1'b0) begin errors++; $display("FAIL cr_idle: got ready=%b fill=%b exp 1/0", bus.miss_ready, bus.fill_valid); end
        checks++; if (n_fill - fill0 != 1 || n_acc - acc0 != 1) begin errors++; $display("FAIL cr_counts: got fills=%0d accepts=%0d exp 1/1", n_fill - fill0, n_acc - acc0); end
    endtask

    task automatic test_wb_fetch;
        bus.set_lines = LINES_DIRTY; bus.miss_addr = 5'b11101; bus.miss_write = 1'b0;
        bus.mem_ack = 1'b0; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.miss_valid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wb_req: got req=%b we=%b exp 1/1", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== 5'b01001 || bus.mem_wdata !== 3'b011) begin errors++; $display("FAIL wb_addr_data: got %b/%b exp 01001/011", bus.mem_addr, bus.mem_wdata); end
        checks++; if (wb_count !== 8'd0) begin errors++; $display("FAIL wb_cnt_before: got %0d exp 0", wb_count); end
        repeat (2) @(negedge clock);
        bus.mem_ack = 1'b1;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (wb_count !== 8'd1) begin errors++; $display("FAIL wb_cnt_after: got %0d exp 1", wb_count); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 5'b11101) begin errors++; $display("FAIL wb_then_fetch: got req=%b we=%b addr=%b exp 1/0/11101", bus.mem_req, bus.mem_we, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 3'b010;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_line !== 9'b110111010) begin errors++; $display("FAIL wb_fill_line: got v=%b line=%b exp 1/110111010", bus.fill_valid, bus.fill_line); end
        checks++; if (bus.fill_way !== 2'd0 || bus.fill_index !== 2'd1) begin errors++; $display("FAIL wb_fill_way_idx: got %0d/%0d exp 0/1", bus.fill_way, bus.fill_index); end
        @(negedge clock);
    endtask

    task automatic test_write_clean;
        int req0;
        req0 = n_req;
        bus.set_lines = LINES_W1INV; bus.miss_addr = 5'b00010; bus.miss_write = 1'b1;
        bus.miss_data = 3'b110; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.miss_valid = 1'b0; bus.miss_write = 1'b0;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_line !== 9'b111000110) begin errors++; $display("FAIL wr_fill_line: got v=%b line=%b exp 1/111000110", bus.fill_valid, bus.fill_line); end
        checks++; if (bus.fill_way !== 2'd1 || bus.fill_index !== 2'd2) begin errors++; $display("FAIL wr_fill_way_idx: got %0d/%0d exp 1/2", bus.fill_way, bus.fill_index); end
        @(negedge clock);
        checks++; if (n_req - req0 != 0) begin errors++; $display("FAIL wr_no_mem: got %0d req cycles exp 0", n_req - req0); end
        checks++; if (bus.miss_ready !== 1'b1 || wb_count !== 8'd1) begin errors++; $display("FAIL wr_idle: got ready=%b cnt=%0d exp 1/1", bus.miss_ready, wb_count); end
    endtask

    task automatic test_timeout;
        int req0, err0, fill0;
        req0 = n_req; err0 = n_err; fill0 = n_fill;
        bus.set_lines = LINES_CLEAN; bus.miss_addr = 5'b01100; bus.miss_write = 1'b0;
        bus.mem_ack = 1'b0; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.miss_valid = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (n_req - req0 != 15) begin errors++; $display("FAIL to_req_cycles: got %0d exp 15", n_req - req0); end
        checks++; if (n_err - err0 != 1) begin errors++; $display("FAIL to_err_pulses: got %0d exp 1", n_err - err0); end
        checks++; if (n_fill - fill0 != 0) begin errors++; $display("FAIL to_no_fill: got %0d exp 0", n_fill - fill0); end
        checks++; if (bus.miss_ready !== 1'b1 || bus.mem_req !== 1'b0 || wb_count !== 8'd1) begin errors++; $display("FAIL to_idle: got ready=%b req=%b cnt=%0d exp 1/0/1", bus.miss_ready, bus.mem_req, wb_count); end
    endtask

    task automatic test_reset_mid_wb;
        int fill0, err0;
        fill0 = n_fill; err0 = n_err;
        bus.set_lines = LINES_DIRTY; bus.miss_addr = 5'b00001; bus.miss_write = 1'b0;
        bus.mem_ack = 1'b0; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.miss_valid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL rw_in_wb: got req=%b we=%b exp 1/1", bus.mem_req, bus.mem_we); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rw_req_drop: got req=%b we=%b exp 0/0", bus.mem_req, bus.mem_we); end
        checks++; if (bus.miss_ready !== 1'b1 || wb_count !== 8'd0) begin errors++; $display("FAIL rw_state: got ready=%b cnt=%0d exp 1/0", bus.miss_ready, wb_count); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (n_fill - fill0 != 0 || n_err - err0 != 0) begin errors++; $display("FAIL rw_no_fill_err: got fills=%0d errs=%0d exp 0/0", n_fill - fill0, n_err - err0); end
    endtask

    task automatic test_busy_hold;
        int acc0, fill0;
        acc0 = n_acc; fill0 = n_fill;
        bus.set_lines = LINES_DIRTY; bus.miss_addr = 5'b10110; bus.miss_write = 1'b1;
        bus.miss_data = 3'b111; bus.mem_ack = 1'b0; bus.miss_valid = 1'b1;
        @(negedge clock);
        bus.set_lines = LINES_W0INV;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'b01010 || bus.mem_wdata !== 3'b011) begin errors++; $display("FAIL bh_wb: got we=%b addr=%b wdata=%b exp 1/01010/011", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        repeat (3) @(negedge clock);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'b01010) begin errors++; $display("FAIL bh_wb_hold: got req=%b addr=%b exp 1/01010", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_line !== 9'b111101111 || bus.fill_way !== 2'd0) begin errors++; $display("FAIL bh_fill1: got v=%b line=%b way=%0d exp 1/111101111/0", bus.fill_valid, bus.fill_line, bus.fill_way); end
        checks++; if (n_acc - acc0 != 1) begin errors++; $display("FAIL bh_one_accept: got %0d exp 1", n_acc - acc0); end
        @(negedge clock);
        checks++; if (bus.miss_ready !== 1'b1 || wb_count !== 8'd1) begin errors++; $display("FAIL bh_idle_gap: got ready=%b cnt=%0d exp 1/1", bus.miss_ready, wb_count); end
        @(negedge clock);
        bus.miss_valid = 1'b0; bus.miss_write = 1'b0;
        checks++; if (bus.fill_valid !== 1'b1 || bus.fill_line !== 9'b111101111 || bus.fill_index !== 2'd2) begin errors++; $display("FAIL bh_fill2: got v=%b line=%b idx=%0d exp 1/111101111/2", bus.fill_valid, bus.fill_line, bus.fill_index); end
        @(negedge clock);
        checks++; if (n_acc - acc0 != 2 || n_fill - fill0 != 2) begin errors++; $display("FAIL bh_totals: got accepts=%0d fills=%0d exp 2/2", n_acc - acc0, n_fill - fill0); end
        checks++; if (wb_count !== 8'd1) begin errors++; $display("FAIL bh_cnt: got %0d exp 1", wb_count); end
    endtask

    initial begin
        test_reset();
        test_clean_read();
        test_wb_fetch();
        test_write_clean();
        test_timeout();
        test_reset_mid_wb();
        test_busy_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
